// File: rtl/otter_mdu_if.sv
`default_nettype none
// ============================================================================
//  Module      : otter_mdu_if
//  Description : Request/response bundle between the Otter control unit and
//                the iterative multiply/divide unit.
//                master : control unit (drives i_start, operands, i_func;
//                         observes o_busy, o_done, o_result)
//                slave  : otter_mdu
//  Revision    : 1.0 - initial release
// ============================================================================
interface otter_mdu_if;
  logic        i_start;   // request, sampled only while the unit is idle
  logic [31:0] i_src_a;   // multiplicand / dividend
  logic [31:0] i_src_b;   // multiplier / divisor
  logic [2:0]  i_func;    // RV32M funct3
  logic        o_busy;    // high whenever the unit is not idle
  logic        o_done;    // one-cycle result-valid pulse
  logic [31:0] o_result;  // registered result, held until the next o_done

  modport master (
    output i_start, i_src_a, i_src_b, i_func,
    input  o_busy, o_done, o_result
  );

  modport slave (
    input  i_start, i_src_a, i_src_b, i_func,
    output o_busy, o_done, o_result
  );
endinterface
`default_nettype wire

// File: rtl/otter_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : otter_mdu
//  Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//                multiply and restoring shift-subtract divide on operand
//                magnitudes, sign fix-up and divide special cases applied in
//                the final step. Fixed 33-cycle start-to-done latency.
//  Ports       : i_clk  - clock, rising edge
//                i_rst  - synchronous active-high reset
//                bus    - otter_mdu_if.slave (start/operands/func in,
//                         busy/done/result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module otter_mdu (
  input  wire logic   i_clk,
  input  wire logic   i_rst,
  otter_mdu_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [2:0]  r_func;
  // Shared working register: multiply uses {partial_hi, multiplier/product_lo},
  // divide uses {remainder, dividend/quotient}.
  logic [63:0] r_acc;
  logic [31:0] r_opnd;    // multiplicand magnitude or divisor magnitude
  logic        r_neg;     // product / quotient must be negated
  logic        r_a_neg;   // remainder must be negated
  logic        r_div0;
  logic        r_ovf;
  logic [31:0] r_src_a;   // original dividend for the divide-by-zero remainder
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;

  // ---------------- operand decode (used only on acceptance) ----------------
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  always_comb begin
    // DIVU/REMU have funct3[2] and funct3[0] set; MULHU is 3.
    w_a_signed = !((bus.i_func == 3'd3) || (bus.i_func[2] && bus.i_func[0]));
    w_b_signed = (bus.i_func == 3'd0) || (bus.i_func == 3'd1) ||
                 (bus.i_func[2] && !bus.i_func[0]);
    w_a_neg    = w_a_signed && bus.i_src_a[31];
    w_b_neg    = w_b_signed && bus.i_src_b[31];
    w_a_mag    = w_a_neg ? (~bus.i_src_a + 32'd1) : bus.i_src_a;
    w_b_mag    = w_b_neg ? (~bus.i_src_b + 32'd1) : bus.i_src_b;
  end

  // ---------------- one iteration step ----------------
  logic [32:0] w_add;
  logic [63:0] w_mul_next;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_div_next;
  logic [63:0] w_next;

  always_comb begin
    w_add      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    w_mul_next = {w_add, r_acc[31:1]};

    // Partial remainder is always below the divisor, so when the trial
    // subtraction succeeds the difference fits in 32 bits and the low-word
    // subtraction is exact.
    w_shift    = {r_acc[63:32], r_acc[31]};
    w_ge       = (w_shift >= {1'b0, r_opnd});
    w_diff     = w_shift[31:0] - r_opnd;
    w_div_next = w_ge ? {w_diff, r_acc[30:0], 1'b1}
                      : {w_shift[31:0], r_acc[30:0], 1'b0};

    w_next     = r_func[2] ? w_div_next : w_mul_next;
  end

  // ---------------- final sign fix-up and special cases ----------------
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_final;

  always_comb begin
    w_prod  = r_neg   ? (~w_next + 64'd1) : w_next;
    w_quo   = r_neg   ? (~w_next[31:0] + 32'd1) : w_next[31:0];
    w_rem   = r_a_neg ? (~w_next[63:32] + 32'd1) : w_next[63:32];
    w_final = 32'd0;
    case (r_func)
      3'd0:                   w_final = w_prod[31:0];
      3'd1, 3'd2, 3'd3:       w_final = w_prod[63:32];
      3'd4, 3'd5: begin
        if (r_div0)           w_final = 32'hFFFF_FFFF;
        else if (r_ovf)       w_final = 32'h8000_0000;
        else                  w_final = w_quo;
      end
      default: begin
        if (r_div0)           w_final = r_src_a;
        else if (r_ovf)       w_final = 32'd0;
        else                  w_final = w_rem;
      end
    endcase
  end

  // ---------------- control ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_count  <= 5'd0;
      r_func   <= 3'd0;
      r_acc    <= 64'd0;
      r_opnd   <= 32'd0;
      r_neg    <= 1'b0;
      r_a_neg  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_src_a  <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_state <= ST_CALC;
            r_busy  <= 1'b1;
            r_count <= 5'd0;
            r_func  <= bus.i_func;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_a_neg <= w_a_neg;
            r_src_a <= bus.i_src_a;
            r_div0  <= (bus.i_src_b == 32'd0);
            r_ovf   <= w_a_signed && w_b_signed &&
                       (bus.i_src_a == 32'h8000_0000) &&
                       (bus.i_src_b == 32'hFFFF_FFFF);
            if (bus.i_func[2]) begin
              r_acc  <= {32'd0, w_a_mag};
              r_opnd <= w_b_mag;
            end else begin
              r_acc  <= {32'd0, w_b_mag};
              r_opnd <= w_a_mag;
            end
          end
        end
        ST_CALC: begin
          r_acc   <= w_next;
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) begin
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_result <= w_final;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_otter_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otter_mdu
//  Description : Directed self-checking bench for otter_mdu. Checks reset
//                state, cycle-exact handshake, every RV32M function class,
//                divide special cases, ignored mid-operation requests,
//                back-to-back issue and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_mdu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  otter_mdu_if bus ();

  otter_mdu dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; that cycle becomes cycle 0 of the request.
  // Returns #1 into cycle 34.
  task automatic run_op(input string tag, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit glitch);
    int          done_cyc = -1;
    int          dones    = 0;
    int          busy_err = 0;
    logic [31:0] res      = 32'hDEAD_BEEF;
    bus.i_start = 1'b1;
    bus.i_func  = f;
    bus.i_src_a = a;
    bus.i_src_b = b;
    for (int c = 1; c <= 34; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_busy !== ((c <= 33) ? 1'b1 : 1'b0)) busy_err++;
      if (bus.o_done === 1'b1) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res      = bus.o_result;
        end
      end
      bus.i_start = 1'b0;
      if (glitch && (c == 5 || c == 20)) begin
        bus.i_start = 1'b1;
        bus.i_func  = 3'd5;
        bus.i_src_a = ~a;
        bus.i_src_b = 32'd3;
      end
    end
    check({tag, "_done_cycle"}, done_cyc, 32'd33);
    check({tag, "_done_count"}, dones, 32'd1);
    check({tag, "_busy_errs"}, busy_err, 32'd0);
    check({tag, "_result"}, res, exp);
  endtask

  task automatic idle(input int n);
    int stray = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) stray++;
    end
    check("idle_quiet", stray, 32'd0);
  endtask

  initial begin
    int stray;
    bus.i_start = 1'b0;
    bus.i_func  = 3'd0;
    bus.i_src_a = 32'd0;
    bus.i_src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_done", {31'd0, bus.o_done}, 32'd0);
    check("rst_result", bus.o_result, 32'd0);
    rst = 1'b0;
    idle(2);

    run_op("mul_7xm3", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    idle(1);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("mulhu",  3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_big",  3'd5, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 1'b0);
    run_op("remu_13_5", 3'd7, 32'd13, 32'd5, 32'd3, 1'b0);
    run_op("div_by0",   3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_by0",   3'd6, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
    idle(2);

    // Ignored mid-operation requests, then immediate back-to-back issue in cycle 34.
    run_op("mul_glitch", 3'd0, 32'd1000, 32'd1000, 32'h000F_4240, 1'b1);
    run_op("divu_b2b",   3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    idle(2);

    // Reset in cycle 10 of a DIV.
    bus.i_start = 1'b1;
    bus.i_func  = 3'd4;
    bus.i_src_a = 32'd100;
    bus.i_src_b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
    end
    check("pre_rst_busy", {31'd0, bus.o_busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("midrst_done", {31'd0, bus.o_done}, 32'd0);
    check("midrst_result", bus.o_result, 32'd0);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_done === 1'b1) stray++;
    end
    check("midrst_no_done", stray, 32'd0);
    run_op("mul_6x7", 3'd0, 32'd6, 32'd7, 32'd42, 1'b0);

    // Reset and start together: request dropped.
    rst = 1'b1;
    bus.i_start = 1'b1;
    bus.i_func  = 3'd0;
    bus.i_src_a = 32'd3;
    bus.i_src_b = 32'd3;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_start_busy", {31'd0, bus.o_busy}, 32'd0);
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
